// File: rtl/decode_issue_ctrl.sv
// Decode/issue controller: IF/ID register, register-usage decode, RAW/WAW scoreboard.
// Optional stall counters under `DECODE_ISSUE_STALL_CNT_EN.
//
// state | meaning
// EMPTY | IF/ID register holds nothing valid
// HOLD  | IF/ID register holds an instruction waiting to issue
module decode_issue_ctrl #(
    parameter int ILEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_valid,
    input  logic [ILEN-1:0]     if_instr,
    output logic                if_ready,
    input  logic                flush,
    output logic [ILEN-1:0]     id_instr,
    input  logic [6:0]          dec_opcode,
    input  logic [REG_AW-1:0]   dec_rd,
    input  logic [REG_AW-1:0]   dec_rs1,
    input  logic [REG_AW-1:0]   dec_rs2,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [ILEN-1:0]     ex_instr,
    output logic                ex_illegal,
    input  logic                wb_valid,
    input  logic [REG_AW-1:0]   wb_rd,
    output logic [1:0]          stall_reason,
`ifdef DECODE_ISSUE_STALL_CNT_EN
    output logic [31:0]         haz_stall_cnt,
    output logic [31:0]         bp_stall_cnt,
`endif
    output logic [NUM_REGS-1:0] pending
);

    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);

    state_t              state, state_nxt;
    logic                id_valid;
    logic                use_rs1, use_rs2, writes_rd, legal;
    logic                use_rs1_q, use_rs2_q, writes_rd_q;
    logic                hazard, issue, accept;
    logic [NUM_REGS-1:0] clr_mask, set_mask, pend_eff;

    assign id_valid   = (state == HOLD);
    assign ex_instr   = id_instr;
    assign ex_illegal = ~legal;

    always_comb begin
        use_rs1_q   = 1'b0;
        use_rs2_q   = 1'b0;
        writes_rd_q = 1'b0;
        legal       = 1'b1;
        case (dec_opcode)
            7'b0110011: begin use_rs1_q = 1'b1; use_rs2_q = 1'b1; writes_rd_q = 1'b1; end
            7'b0010011,
            7'b0000011,
            7'b1100111: begin use_rs1_q = 1'b1; writes_rd_q = 1'b1; end
            7'b0100011,
            7'b1100011: begin use_rs1_q = 1'b1; use_rs2_q = 1'b1; end
            7'b1101111,
            7'b0110111,
            7'b0010111: writes_rd_q = 1'b1;
            default:    legal = 1'b0;
        endcase
    end

    // x0 is hardwired, so it never creates a dependency
    assign use_rs1   = use_rs1_q   & (dec_rs1 != '0);
    assign use_rs2   = use_rs2_q   & (dec_rs2 != '0);
    assign writes_rd = writes_rd_q & (dec_rd  != '0);

    assign clr_mask = wb_valid ? (ONE << wb_rd) : '0;
    assign pend_eff = pending & ~clr_mask;
    assign hazard   = (use_rs1 & pend_eff[dec_rs1]) |
                      (use_rs2 & pend_eff[dec_rs2]) |
                      (writes_rd & pend_eff[dec_rd]);
    assign set_mask = (issue & writes_rd) ? (ONE << dec_rd) : '0;

    always_comb begin
        state_nxt    = state;
        ex_valid     = 1'b0;
        issue        = 1'b0;
        if_ready     = 1'b0;
        accept       = 1'b0;
        stall_reason = 2'b00;
        if (!rst) begin
            ex_valid = id_valid & ~hazard & ~flush;
            issue    = ex_valid & ex_ready;
            if_ready = ~id_valid | issue | flush;
            accept   = if_valid & if_ready;
            if (id_valid & hazard)
                stall_reason = 2'b01;
            else if (id_valid & ~ex_ready)
                stall_reason = 2'b10;
            case (state)
                EMPTY: if (accept) state_nxt = HOLD;
                HOLD: begin
                    if (accept)              state_nxt = HOLD;
                    else if (issue | flush)  state_nxt = EMPTY;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // set after clear so an issue re-claiming a register being written back wins
    always_ff @(posedge clk) begin
        if (rst) begin
            id_instr <= '0;
            pending  <= '0;
        end else begin
            if (accept)
                id_instr <= if_instr;
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

`ifdef DECODE_ISSUE_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            haz_stall_cnt <= '0;
            bp_stall_cnt  <= '0;
        end else begin
            if (stall_reason == 2'b01) haz_stall_cnt <= haz_stall_cnt + 32'd1;
            if (stall_reason == 2'b10) bp_stall_cnt  <= bp_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Self-checking bench for decode_issue_ctrl: issued instructions checked against a
// queue of expected issues; scoreboard and handshake checked at key points.
module tb_decode_issue_ctrl;

    localparam logic [31:0] ADDI1 = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] ADD2  = 32'h00108133;  // add  x2,x1,x1
    localparam logic [31:0] ADDI3 = 32'h00500193;  // addi x3,x0,5
    localparam logic [31:0] ILL   = 32'hFFFFFFFF;

    typedef struct packed {
        logic [31:0] instr;
        logic        ill;
    } exp_t;

    logic        clk, rst;
    logic        if_valid, if_ready, flush;
    logic [31:0] if_instr, id_instr, ex_instr;
    logic [6:0]  dec_opcode;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2, wb_rd;
    logic        ex_valid, ex_ready, ex_illegal, wb_valid;
    logic [1:0]  stall_reason;
    logic [31:0] pending;
`ifdef DECODE_ISSUE_STALL_CNT_EN
    logic [31:0] haz_stall_cnt, bp_stall_cnt;
`endif

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // instruction decoder stand-in: plain RV32 field extraction
    assign dec_opcode = id_instr[6:0];
    assign dec_rd     = id_instr[11:7];
    assign dec_rs1    = id_instr[19:15];
    assign dec_rs2    = id_instr[24:20];

    decode_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
        .flush(flush), .id_instr(id_instr),
        .dec_opcode(dec_opcode), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_instr(ex_instr), .ex_illegal(ex_illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .stall_reason(stall_reason),
`ifdef DECODE_ISSUE_STALL_CNT_EN
        .haz_stall_cnt(haz_stall_cnt), .bp_stall_cnt(bp_stall_cnt),
`endif
        .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic ill);
        exp_t e;
        e.instr = instr;
        e.ill   = ill;
        q.push_back(e);
    endtask

    // issue monitor, sampled late in the cycle after all stimulus has settled
    always @(negedge clk) begin
        exp_t e;
        #3;
        if (!rst && ex_valid && ex_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_issue", ex_instr, 32'h0);
            end else begin
                e = q.pop_front();
                chk("ex_instr", ex_instr, e.instr);
                chk("ex_illegal", 32'(ex_illegal), 32'(e.ill));
            end
        end
    end

    initial begin
        exp_t drop;
        rst = 1'b1; if_valid = 1'b0; if_instr = '0; flush = 1'b0;
        ex_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0;
        cyc();
        @(negedge clk);
        chk("rst_if_ready", 32'(if_ready), 0);
        chk("rst_ex_valid", 32'(ex_valid), 0);
        chk("rst_stall", 32'(stall_reason), 0);
        cyc(); rst = 1'b0;
        @(negedge clk);
        chk("idle_if_ready", 32'(if_ready), 1);
        chk("idle_ex_valid", 32'(ex_valid), 0);
        chk("idle_pending", pending, 0);
        chk("idle_stall", 32'(stall_reason), 0);

        // single addi: issuable one cycle after accept
        cyc(); if_valid = 1'b1; if_instr = ADDI1; ex_ready = 1'b1; push(ADDI1, 1'b0);
        cyc(); if_valid = 1'b0;
        @(negedge clk);
        chk("t1_ex_valid", 32'(ex_valid), 1);
        chk("t1_id_instr", id_instr, ADDI1);
        cyc();
        @(negedge clk);
        chk("t1_pending", pending, 32'h2);
        chk("t1_ex_valid_after", 32'(ex_valid), 0);

        // writeback of x0 is ignored, of x1 clears
        wb_valid = 1'b1; wb_rd = 5'd0;
        cyc();
        @(negedge clk);
        chk("wb_x0_noeffect", pending, 32'h2);
        wb_rd = 5'd1;
        cyc(); wb_valid = 1'b0;
        @(negedge clk);
        chk("wb_x1_clear", pending, 32'h0);

        // addi x1 then dependent add back-to-back
        if_valid = 1'b1; if_instr = ADDI1; push(ADDI1, 1'b0);
        cyc(); if_instr = ADD2; push(ADD2, 1'b0);
        cyc(); if_valid = 1'b0;
        @(negedge clk);
        chk("t2_stall_haz", 32'(stall_reason), 1);
        chk("t2_if_ready", 32'(if_ready), 0);
        chk("t2_ex_valid", 32'(ex_valid), 0);
        chk("t2_id_instr", id_instr, ADD2);
        cyc();
        @(negedge clk);
        chk("t2_pending_x1", pending, 32'h2);
        wb_valid = 1'b1; wb_rd = 5'd1;
        #1;
        chk("t2_wb_bypass_valid", 32'(ex_valid), 1);
        cyc(); wb_valid = 1'b0;
        @(negedge clk);
        chk("t2_pending_x2", pending, 32'h4);
        wb_valid = 1'b1; wb_rd = 5'd2;
        cyc(); wb_valid = 1'b0;
        @(negedge clk);
        chk("t2_pending_clear", pending, 32'h0);

        // execute backpressure
        ex_ready = 1'b0; if_valid = 1'b1; if_instr = ADDI1; push(ADDI1, 1'b0);
        cyc(); if_valid = 1'b0;
        @(negedge clk);
        chk("t3_stall_bp", 32'(stall_reason), 2);
        chk("t3_if_ready", 32'(if_ready), 0);
        chk("t3_ex_valid", 32'(ex_valid), 1);
        cyc();
        @(negedge clk);
        chk("t3_id_stable", id_instr, ADDI1);
        ex_ready = 1'b1;
        #1;
        chk("t3_if_ready_on_issue", 32'(if_ready), 1);
        cyc();
        @(negedge clk);
        chk("t3_pending", pending, 32'h2);
        chk("t3_ex_valid_after", 32'(ex_valid), 0);

        // flush a hazard-stalled add
        if_valid = 1'b1; if_instr = ADD2; push(ADD2, 1'b0);
        cyc(); if_valid = 1'b0;
        @(negedge clk);
        chk("t4_stall_haz", 32'(stall_reason), 1);
        flush = 1'b1; drop = q.pop_back();
        #1;
        chk("t4_flush_no_issue", 32'(ex_valid), 0);
        chk("t4_flush_if_ready", 32'(if_ready), 1);
        cyc(); flush = 1'b0;
        @(negedge clk);
        chk("t4_empty_ex_valid", 32'(ex_valid), 0);
        chk("t4_empty_stall", 32'(stall_reason), 0);
        chk("t4_pending_kept", pending, 32'h2);

        // illegal opcode still issues, no scoreboard effect
        if_valid = 1'b1; if_instr = ILL; push(ILL, 1'b1);
        cyc(); if_valid = 1'b0;
        @(negedge clk);
        chk("t5_illegal", 32'(ex_illegal), 1);
        chk("t5_ex_valid", 32'(ex_valid), 1);
        cyc();
        @(negedge clk);
        chk("t5_pending", pending, 32'h2);

        // flush with a same-cycle accept keeps the new instruction
        if_valid = 1'b1; if_instr = ADD2; push(ADD2, 1'b0);
        cyc(); if_valid = 1'b0;
        @(negedge clk);
        chk("t6_stall_haz", 32'(stall_reason), 1);
        flush = 1'b1; if_valid = 1'b1; if_instr = ADDI3;
        drop = q.pop_back(); push(ADDI3, 1'b0);
        cyc(); flush = 1'b0; if_valid = 1'b0;
        @(negedge clk);
        chk("t6_id_instr", id_instr, ADDI3);
        chk("t6_ex_valid", 32'(ex_valid), 1);
        cyc();
        @(negedge clk);
        chk("t6_pending", pending, 32'hA);

        // reset while holding a stalled instruction
        if_valid = 1'b1; if_instr = ADD2; push(ADD2, 1'b0);
        cyc(); if_valid = 1'b0;
        @(negedge clk);
        chk("t7_stall_haz", 32'(stall_reason), 1);
        rst = 1'b1; drop = q.pop_back();
        #1;
        chk("t7_rst_if_ready", 32'(if_ready), 0);
        chk("t7_rst_ex_valid", 32'(ex_valid), 0);
        chk("t7_rst_stall", 32'(stall_reason), 0);
        cyc(); rst = 1'b0;
        @(negedge clk);
        chk("t7_pending", pending, 32'h0);
        chk("t7_ex_valid", 32'(ex_valid), 0);
        chk("t7_if_ready", 32'(if_ready), 1);
        chk("t7_id_instr", id_instr, 32'h0);

        repeat (3) cyc();
        chk("queue_drained", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
- Sequences the decode stage: owns the IF/ID instruction register and drives the instruction decoder from it.
- Takes the decoder's fields back, tracks in-flight destination registers in a 32-entry scoreboard, and issues to execute only when free of RAW/WAW hazards and not back-pressured.
- Sits between fetch (valid/ready) and execute (valid/ready); writeback clears scoreboard entries.

Parameters:
- ILEN, 32, instruction width
- NUM_REGS, 32, architectural registers tracked (x0 never pending)
- REG_AW, 5, register index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_valid  in  1  fetch offers instruction
- if_instr  in  ILEN  fetched instruction
- if_ready  out  1  ID register can accept this cycle
- flush  in  1  discard ID register contents
- id_instr  out  ILEN  IF/ID register, feeds decoder instruction input
- dec_opcode  in  7  decoder opcode
- dec_rd  in  REG_AW  decoder rd
- dec_rs1  in  REG_AW  decoder rs1
- dec_rs2  in  REG_AW  decoder rs2
- ex_valid  out  1  issue offer to execute
- ex_ready  in  1  execute accepts
- ex_instr  out  ILEN  instruction being issued (equals id_instr)
- ex_illegal  out  1  opcode not in supported set
- wb_valid  in  1  writeback completes
- wb_rd  in  REG_AW  register written back
- stall_reason  out  2  00 none/empty, 01 hazard, 10 execute backpressure
- pending  out  NUM_REGS  scoreboard bit vector

Behaviour:
- State machine: EMPTY (id_valid=0), HOLD (id_valid=1). Reset: EMPTY, id_instr=0, pending=0.
- While rst=1: if_ready=0, ex_valid=0, stall_reason=00.
- Register usage by dec_opcode:
  - rs1 used: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - rs2 used: 0110011, 0100011, 1100011.
  - rd written: 0110011, 0010011, 0000011, 1101111, 1100111, 0110111, 0010111.
  - Any other opcode: ex_illegal=1, no uses, no rd write; still issued.
  - Index 0 never counts as use/write.
- pend_eff = pending with bit wb_rd cleared when wb_valid.
- hazard = (use_rs1 & pend_eff[rs1]) | (use_rs2 & pend_eff[rs2]) | (writes_rd & pend_eff[rd]).
- ex_valid = id_valid & ~hazard & ~flush. Issue = ex_valid & ex_ready.
- if_ready = ~rst & (~id_valid | issue | flush).
- Accept (if_valid & if_ready): id_instr <= if_instr, HOLD at next edge.
  - Latency: accepted at edge N, issuable in cycle N+1.
  - Back-to-back issue at 1/cycle when hazard-free.
- Issue without accept -> EMPTY; issue with accept -> stay HOLD with new instruction.
- flush: ID contents dropped, no issue, scoreboard untouched. Accept in the same cycle is allowed; the new instruction is kept.
- Scoreboard per edge:
  - Clear bit wb_rd on wb_valid.
  - Set bit rd on issue with writes_rd.
  - Same index set and cleared in the same cycle: set wins.
  - wb_valid with wb_rd=0 or a non-pending rd: no effect.
- stall_reason: 01 if id_valid & hazard; 10 if id_valid & ~hazard & ~ex_ready; else 00.
- Reset mid-HOLD: instruction discarded, all pending cleared.

Optional Feature:
- Macro: DECODE_ISSUE_STALL_CNT_EN.
- Defined: adds outputs haz_stall_cnt[31:0] and bp_stall_cnt[31:0].
  - Each increments on every cycle stall_reason is 01 or 10 respectively.
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters absent; no other behaviour change.

Test Plan:
- Reset, then idle -> if_ready=1, ex_valid=0, pending=0, stall_reason=00.
- if_instr=0x00500093 (addi x1,x0,5), ex_ready=1 -> ex_valid=1 one cycle after accept; after issue pending[1]=1.
- addi x1 then 0x00108133 (add x2,x1,x1) back-to-back, no wb -> add holds with stall_reason=01 and if_ready=0.
  - wb_valid=1, wb_rd=1 -> add issues in that same cycle; then pending[2]=1, pending[1]=0.
- ex_ready=0 with hazard-free 0x00500093 held -> stall_reason=10, id_instr stable, if_ready=0.
  - Raise ex_ready -> issue in that cycle, and if_ready=1 in that same cycle.
- flush while add x2 is stalled on hazard -> EMPTY next cycle, no issue, pending[1] stays 1.
- if_instr=0xFFFFFFFF -> ex_illegal=1, issued, pending unchanged.
- Assert rst while HOLD with pending[1]=1 -> next cycle EMPTY, pending=0.
